// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: format codes, opcodes,
// FIFO state encoding and the field-to-word encode function.
package riscv_enc_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } fifo_state_e;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
   } fields_t;

   // Illegal format codes fall through to the R layout.
   function automatic logic [31:0] encode(input logic [2:0] fmt, input fields_t f);
      logic [31:0] word;
      case (fmt_e'(fmt))
         FMT_I:   word = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
         FMT_S:   word = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
         FMT_B:   word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3,
                          f.imm[4:1], f.imm[11], f.op};
         FMT_U:   word = {f.imm[31:12], f.rd, f.op};
         FMT_J:   word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                          f.rd, f.op};
         default: word = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bundle/word handshake between the stimulus source and the encoder.
// master = source/sink side, slave = encoder side.
interface instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        fmt;
   logic [6:0]        cmdOp;
   logic [2:0]        cmdF3;
   logic [6:0]        cmdF7;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [4:0]        rd;
   logic [31:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic [ADDR_W:0]   count;
   logic              err;

   modport master (
      output in_valid, fmt, cmdOp, cmdF3, cmdF7, rs1, rs2, rd, imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, count, err
   );

   modport slave (
      input  in_valid, fmt, cmdOp, cmdF3, cmdF7, rs1, rs2, rd, imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, count, err
   );
endinterface

// File: rtl/instr_encoder_fifo2.sv
// Two-entry FIFO with the head held in a dedicated register so the output
// data comes straight from a flop.
module enc_fifo2
   import riscv_enc_pkg::*;
#(
   parameter int W = 42
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   fifo_state_e  r_state;
   fifo_state_e  w_next;
   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic         w_push;
   logic         w_pop;

   assign w_push = i_push && (r_state != ST_FULL);
   assign w_pop  = i_pop  && (r_state != ST_EMPTY);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_next;
   end

   // NOTE: default assignment first keeps this combinational block latch-free.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_push)            w_next = ST_ONE;
         ST_ONE:   if (w_push && !w_pop)  w_next = ST_FULL;
                   else if (!w_push && w_pop) w_next = ST_EMPTY;
         ST_FULL:  if (w_pop)             w_next = ST_ONE;
         default:                         w_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      o_full  = (r_state == ST_FULL);
      o_empty = (r_state == ST_EMPTY);
   end

   // NOTE: both entries are reset because the head is visible on the output right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_push) r_head <= i_data;
            ST_ONE: begin
               if (w_push && w_pop) r_head <= i_data;
               else if (w_push)     r_tail <= i_data;
            end
            ST_FULL:  if (w_pop)  r_head <= r_tail;
            default: ;
         endcase
      end
   end

   assign o_data = r_head;
endmodule

// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder with sequential word addressing and a 2-entry
// output buffer. Define ENC_CHECK_EN to enable the sticky immediate/format error.
module instr_encoder
   import riscv_enc_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   instr_encoder_if.slave  bus
);
   localparam int                DATA_W  = 32 + ADDR_W;
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_MAX = '1;

   fields_t           w_fields;
   logic [31:0]       w_instr;
   logic [ADDR_W-1:0] w_cur_addr;
   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_pop;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;

   always_comb begin
      w_fields = '{op: bus.cmdOp, f3: bus.cmdF3, f7: bus.cmdF7, rs1: bus.rs1,
                   rs2: bus.rs2, rd: bus.rd, imm: bus.imm};
      w_instr  = encode(bus.fmt, w_fields);
   end

   assign w_accept   = bus.in_valid && !w_full;
   assign w_pop      = !w_empty && bus.out_ready;
   // A start in the accept cycle hands BASE to that very word.
   assign w_cur_addr = start ? BASE : r_addr;

   enc_fifo2 #(.W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_pop   (w_pop),
      .i_data  ({w_instr, w_cur_addr}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.in_ready  = !w_full;
   assign bus.out_valid = !w_empty;
   assign bus.out_instr = w_head[DATA_W-1 -: 32];
   assign bus.out_addr  = w_head[ADDR_W-1:0];
   assign bus.count     = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= BASE;
         r_count <= '0;
      end else begin
         if (w_accept)   r_addr <= w_cur_addr + ADDR_1;
         else if (start) r_addr <= BASE;

         if (start)                                r_count <= w_accept ? CNT_ONE : '0;
         else if (w_accept && r_count != CNT_MAX)  r_count <= r_count + CNT_ONE;
      end
   end

`ifdef ENC_CHECK_EN
   logic w_bad;
   logic w_sx12;
   logic w_sx13;
   logic w_sx21;
   logic r_err;

   always_comb begin
      w_sx12 = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
      w_sx13 = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
      w_sx21 = (&bus.imm[31:20]) || !(|bus.imm[31:20]);
      w_bad  = 1'b0;
      case (fmt_e'(bus.fmt))
         FMT_R:        w_bad = 1'b0;
         FMT_I, FMT_S: w_bad = !w_sx12;
         FMT_B:        w_bad = bus.imm[0] || !w_sx13;
         FMT_U:        w_bad = |bus.imm[11:0];
         FMT_J:        w_bad = bus.imm[0] || !w_sx21;
         default:      w_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                     r_err <= 1'b0;
      else if (start)              r_err <= w_accept && w_bad;
      else if (w_accept && w_bad)  r_err <= 1'b1;
   end

   assign bus.err = r_err;
`else
   logic w_unused_imm0;
   assign w_unused_imm0 = bus.imm[0];
   assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder (ADDR_W=2 to exercise wrap and
// count saturation); err expectations follow ENC_CHECK_EN.
module tb_instr_encoder;
   import riscv_enc_pkg::*;

   localparam int ADDR_W    = 2;
   localparam int BASE_ADDR = 0;
   localparam int CNT_MAX   = 7;

`ifdef ENC_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0]       instr;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;

   exp_t              q[$];
   int                total = 0;
   int                bad   = 0;
   logic [ADDR_W-1:0] nxt_addr  = ADDR_W'(BASE_ADDR);
   int                exp_count = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rdd, input logic [31:0] im);
      bus.fmt   = f;
      bus.cmdOp = op;
      bus.cmdF3 = f3;
      bus.cmdF7 = f7;
      bus.rs1   = r1;
      bus.rs2   = r2;
      bus.rd    = rdd;
      bus.imm   = im;
   endtask

   // Holds the bundle until accepted; the expected word is queued on the accepting edge.
   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdd, input logic [31:0] im, input logic [31:0] exp_instr);
      logic              done;
      logic [ADDR_W-1:0] a;
      done = 1'b0;
      drive(f, op, f3, f7, r1, r2, rdd, im);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            a = start ? ADDR_W'(BASE_ADDR) : nxt_addr;
            q.push_back('{instr: exp_instr, addr: a});
            nxt_addr  = a + ADDR_W'(1);
            exp_count = start ? 1 : ((exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("accept", 64'(done), 64'(1));
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 20 && (q.size() != 0 || bus.out_valid); n++) tick();
      check("drain", 64'(q.size()), 64'(0));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", 64'(q.size() != 0), 64'(1));
         if (q.size() != 0) begin
            e = q.pop_front();
            check("out_instr", 64'(bus.out_instr), 64'(e.instr));
            check("out_addr", 64'(bus.out_addr), 64'(e.addr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

      tick();
      tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_instr", 64'(bus.out_instr), 64'(0));
      check("rst_out_addr", 64'(bus.out_addr), 64'(0));
      check("rst_count", 64'(bus.count), 64'(0));
      check("rst_err", 64'(bus.err), 64'(0));
      rst = 1'b0;
      tick();
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));

      // add x3,x1,x2 with the sink stalled: visible the cycle after accept
      send(FMT_R, OP_REG, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
      check("lat_valid", 64'(bus.out_valid), 64'(1));
      check("lat_instr", 64'(bus.out_instr), 64'(32'h002081B3));
      check("lat_addr", 64'(bus.out_addr), 64'(0));
      bus.out_ready = 1'b1;

      // addi with junk in unused fields, beq, sw, lui (address wraps to 0)
      send(FMT_I, OP_IMM, 3'd0, 7'h7F, 5'd0, 5'd31, 5'd5, 32'hFFFF_FFFF, 32'hFFF00293);
      send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00208463);
      send(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd12, 32'h0020A623);
      send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h1234_5000, 32'h123453B7);
      check("count_5", 64'(bus.count), 64'(5));
      send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd16, 32'h010000EF);
      send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDFF06F);
      // illegal fmt encodes as R (sub x3,x1,x2); eighth accept saturates count
      send(3'd7, OP_REG, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 32'h402081B3);
      check("count_sat", 64'(bus.count), 64'(CNT_MAX));
      check("err_illegal_fmt", 64'(bus.err), 64'(ERR_ON));

      // start coincident with an accept
      start = 1'b1;
      send(FMT_R, OP_REG, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
      start = 1'b0;
      check("start_count", 64'(bus.count), 64'(1));
      check("start_err", 64'(bus.err), 64'(0));
      send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 32'hFFF00293);
      check("count_model", 64'(bus.count), 64'(exp_count));

      // misaligned J immediate: still emitted, truncated
      send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd3, 32'h002000EF);
      check("err_j_imm", 64'(bus.err), 64'(ERR_ON));
      start = 1'b1;
      tick();
      start     = 1'b0;
      nxt_addr  = ADDR_W'(BASE_ADDR);
      exp_count = 0;
      check("start_clr_err", 64'(bus.err), 64'(0));
      check("start_clr_count", 64'(bus.count), 64'(0));
      send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00208463);
      wait_drain();

      // fill the buffer with the sink stalled; third bundle must wait
      bus.out_ready = 1'b0;
      send(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd12, 32'h0020A623);
      send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h1234_5000, 32'h123453B7);
      drive(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd16);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("full_in_ready", 64'(bus.in_ready), 64'(0));
      check("full_out_valid", 64'(bus.out_valid), 64'(1));
      tick();
      @(negedge clk);
      check("full_hold", 64'(bus.in_ready), 64'(0));
      check("full_head_stable", 64'(bus.out_instr), 64'(32'h0020A623));
      tick();
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("no_comb_ready", 64'(bus.in_ready), 64'(0));
      tick();
      send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd16, 32'h010000EF);
      wait_drain();
      check("count_after_fill", 64'(bus.count), 64'(exp_count));

      // reset with the buffer full discards both words
      bus.out_ready = 1'b0;
      send(FMT_R, OP_REG, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
      send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 32'hFFF00293);
      check("pre_rst_full", 64'(bus.in_ready), 64'(0));
      rst = 1'b1;
      q.delete();
      tick();
      rst       = 1'b0;
      nxt_addr  = ADDR_W'(BASE_ADDR);
      exp_count = 0;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_count", 64'(bus.count), 64'(0));
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
      bus.out_ready = 1'b1;
      send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h1234_5000, 32'h123453B7);
      wait_drain();
      check("post_rst_count", 64'(bus.count), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Assembles RV32I instruction words from decoded-field bundles: opcode, funct3, funct7, register addresses and immediate, plus a format select.
- It is the inverse of the instruction field decoder. It sits between the program-load/test-stimulus path and the instruction memory write port.
- Emits encoded words with sequential word addresses through a 2-entry valid/ready buffer.

## Interface
Parameters:
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, address assigned to first word after reset/start

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  restart address sequence at BASE_ADDR
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept bundle
- fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal
- cmdOp  input  7  opcode field
- cmdF3  input  3  funct3
- cmdF7  input  7  funct7 (R only)
- rs1, rs2, rd  input  5 each  register addresses
- imm  input  32  immediate, byte-offset form, sign-extended
- out_valid  output  1  encoded word available
- out_ready  input  1  downstream accepts word
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  word address of out_instr
- count  output  ADDR_W+1  words accepted since reset/start, saturating
- err  output  1  sticky encoding error (see Configuration)

## Operation
- Accept occurs when in_valid && in_ready. The bundle is encoded combinationally and pushed with the current address counter value.
- The address counter then increments, wrapping modulo 2^ADDR_W.
- Encoding, with bit 31 leftmost:
  - R: F7|rs2|rs1|F3|rd|op
  - I: imm[11:0]|rs1|F3|rd|op
  - S: imm[11:5]|rs2|rs1|F3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|F3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Unused fields are ignored. Illegal fmt encodes as R.
- Output buffer is a 2-entry FIFO, states EMPTY/ONE/FULL.
  - in_ready = (state != FULL). It has no combinational dependence on out_ready.
  - out_valid = (state != EMPTY). out_instr/out_addr show the head entry.
  - Push and pop in the same cycle leave the state unchanged.
  - A push is never accepted in FULL, even if a pop occurs that cycle.
- count increments per accept and saturates at 2^(ADDR_W+1)-1.
- start:
  - The counter loads BASE_ADDR and count clears.
  - If an accept occurs in the same cycle, that word takes BASE_ADDR, the counter becomes BASE_ADDR+1, and count becomes 1.
  - start does not flush the FIFO and does not stall.
- Reset values: out_valid=0, out_instr=0, out_addr=0, count=0, err=0, address counter=BASE_ADDR, FIFO EMPTY.
  - in_ready=1 from the first cycle after rst deasserts.
  - rst mid-operation discards buffered words.

## Timing
- Latency: a word accepted in cycle N is visible with out_valid=1 in cycle N+1 when the FIFO was EMPTY. Otherwise it follows FIFO order.
- Throughput: 1 word/cycle sustained while out_ready=1.
- out_instr/out_addr are stable while out_valid && !out_ready.
- All outputs are registered except in_ready and out_valid, which decode directly from state flops.

## Configuration
- ENC_CHECK_EN defined: err sets on an accept with any of these conditions:
  - illegal fmt
  - I/S imm not a 12-bit sign extension
  - B imm[0]!=0 or outside 13-bit signed range
  - J imm[0]!=0 or outside 21-bit signed range
  - U imm[11:0]!=0
- Under ENC_CHECK_EN, the offending word is still encoded (truncated) and emitted. err clears only on rst or start.
- ENC_CHECK_EN undefined: no range-check logic; err is tied to 0.

## Structure
- Package riscv_enc_pkg holds:
  - format codes FMT_R..FMT_J
  - RV32I opcode constants (OP_REG 0x33, OP_IMM 0x13, OP_STORE 0x23, OP_BRANCH 0x63, OP_LUI 0x37, OP_JAL 0x6F)
  - an encode function taking fmt and fields, returning 32 bits
- Sub-module enc_fifo2 is a 2-entry FIFO parameterized on data width (32+ADDR_W) with push/pop/full/empty.

## Test plan
- R add x3,x1,x2 (op 0x33, F3 0, F7 0, rs1 1, rs2 2, rd 3) after reset -> out_instr 0x002081B3, out_addr 0, out_valid one cycle after accept.
- I addi x5,x0,-1 (op 0x13, imm 0xFFFFFFFF, rd 5) -> 0xFFF00293. B beq x1,x2,+8 (op 0x63, imm 8) -> 0x00208463.
- out_ready=0, 3 back-to-back bundles -> in_ready low after 2 accepts, third held. Raising out_ready drains addresses 0,1,2 in order with no loss or duplication.
- ADDR_W=2, 5 accepts -> out_addr 0,1,2,3,0 and count=5. start asserted with a 6th accept -> that word gets out_addr 0, count=1.
- Reset asserted with FIFO FULL -> next cycle out_valid=0, count=0, in_ready=1. Later accepts restart at BASE_ADDR.
- ENC_CHECK_EN: J with imm=3 -> err=1 and the word is still emitted. start -> err=0. Without the macro, the same stimulus leaves err=0.
